// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 program-loading blocks.
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and word widths
//   estado_e                : loader state codes (also visible on the debug port)
//   prox_pos_escrita        : state that follows a completed write (and verify)
package sap1_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESCREVE  = 3'd1,
    VERIFICA = 3'd2,
    CHEIO    = 3'd3,
    EXECUTA  = 3'd4
  } estado_e;

  // A run request seen while a word is in flight goes straight to EXECUTA,
  // never back through OCIOSO. Otherwise CHEIO once the RAM is full.
  function automatic estado_e prox_pos_escrita(input logic run, input logic cheio);
    estado_e prox;
    if (run) begin
      prox = EXECUTA;
    end else if (cheio) begin
      prox = CHEIO;
    end else begin
      prox = OCIOSO;
    end
    return prox;
  endfunction

endpackage

// File: rtl/sap1_sincronizador.sv
// Two-flop synchroniser for signals arriving from outside the clk_in domain.
// Each bit is synchronised independently; only use W>1 for bits that are
// independent of each other (no multi-bit coherency is provided).
//
// Ports:
//   clk_in           : destination clock, rising edge
//   limpar_iniciar_n : asynchronous active-low reset, clears both stages
//   d_in  [W-1:0]    : asynchronous input
//   q_out [W-1:0]    : synchronised output, two clk_in edges after d_in
module sap1_sincronizador #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         limpar_iniciar_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sinc_d, sinc_q;

  always_comb begin
    meta_d = d_in;
    sinc_d = meta_q;
  end

  always_ff @(posedge clk_in or negedge limpar_iniciar_n) begin
    if (!limpar_iniciar_n) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign q_out = sinc_q;

endmodule

// File: rtl/sap1_carregador_ram.sv
// Program loader for the SAP-1 program RAM.
//
// In programming mode (run_prog=0) words offered on dado_valido/dado_in are
// written to consecutive RAM addresses starting at 0. In execution mode
// (run_prog=1) the CPU address drives the RAM and every write is blocked.
//
// Optional build macro: CARREGADOR_VERIFICA_EN adds a read-back state
// (VERIFICA) after each write and a sticky erro_verificacao flag.
//
// Handshake: a word transfers on a rising clk_in edge where dado_valido and
// dado_pronto are both high. dado_in is sampled only on that edge; the source
// must hold dado_valido until it sees dado_pronto and may change dado_in at
// any other time.
//
// Ports:
//   clk_in, limpar_iniciar_n : clock (rising) and async active-low reset
//   run_prog                 : 0 = program, 1 = execute (asynchronous input)
//   dado_valido, dado_in     : source word and its valid
//   dado_pronto              : loader ready for a word
//   cpu_end                  : CPU address, routed to ram_end in EXECUTA
//   ram_end, ram_dado, ram_we: RAM address, write data, write strobe
//   ram_dado_lido            : RAM read data (verify build only)
//   cpu_executar             : CPU owns the RAM
//   palavras                 : words loaded, 0..2**ADDR_W
//   erro_overflow            : sticky, word offered while full
//   erro_verificacao         : sticky, read-back mismatch (0 without macro)
//   estado                   : current state code, for debug
module sap1_carregador_ram
  import sap1_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              limpar_iniciar_n,
  input  logic              run_prog,
  input  logic              dado_valido,
  input  logic [DATA_W-1:0] dado_in,
  output logic              dado_pronto,
  input  logic [ADDR_W-1:0] cpu_end,
  output logic [ADDR_W-1:0] ram_end,
  output logic [DATA_W-1:0] ram_dado,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dado_lido,
  output logic              cpu_executar,
  output logic [ADDR_W:0]   palavras,
  output logic              erro_overflow,
  output logic              erro_verificacao,
  output logic [2:0]        estado
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PAL_UM  = 1;
  localparam logic [ADDR_W-1:0] PTR_UM  = 1;

  logic run_s;

  sap1_sincronizador #(.W(1)) u_sinc_run (
    .clk_in           (clk_in),
    .limpar_iniciar_n (limpar_iniciar_n),
    .d_in             (run_prog),
    .q_out            (run_s)
  );

  estado_e           state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [ADDR_W:0]   palavras_d, palavras_q;
  logic [ADDR_W-1:0] ram_end_d, ram_end_q;
  logic [DATA_W-1:0] ram_dado_d, ram_dado_q;
  logic              ram_we_d, ram_we_q;
  logic              pronto_d, pronto_q;
  logic              exec_d, exec_q;
  logic              ovf_d, ovf_q;
  logic              handshake;
  logic [ADDR_W:0]   palavras_inc;

`ifdef CARREGADOR_VERIFICA_EN
  logic ver_d, ver_q;
`else
  logic unused_lido;
  assign unused_lido = ^ram_dado_lido;
`endif

  // pronto_q says "next cycle is OCIOSO"; run_s is ANDed in combinationally so
  // a run request blocks the handshake in the very cycle it is seen.
  assign dado_pronto  = pronto_q & ~run_s;
  assign handshake    = dado_valido & dado_pronto;
  assign palavras_inc = palavras_q + PAL_UM;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    palavras_d = palavras_q;
    ram_end_d  = ram_end_q;
    ram_dado_d = ram_dado_q;
    ovf_d      = ovf_q;
`ifdef CARREGADOR_VERIFICA_EN
    ver_d      = ver_q;
`endif

    case (state_q)
      OCIOSO: begin
        if (run_s) begin
          state_d = EXECUTA;
        end else if (handshake) begin
          ram_dado_d = dado_in;
          ram_end_d  = ptr_q;
          state_d    = ESCREVE;
        end
      end

      ESCREVE: begin
        ptr_d      = ptr_q + PTR_UM;
        palavras_d = palavras_inc;
`ifdef CARREGADOR_VERIFICA_EN
        state_d    = VERIFICA;
`else
        state_d    = prox_pos_escrita(run_s, palavras_inc == DEPTH);
`endif
      end

`ifdef CARREGADOR_VERIFICA_EN
      // ram_end still holds the written address; the synchronous RAM
      // presents that word on ram_dado_lido during this cycle.
      VERIFICA: begin
        if (ram_dado_lido != ram_dado_q) begin
          ver_d = 1'b1;
        end
        state_d = prox_pos_escrita(run_s, palavras_q == DEPTH);
      end
`endif

      CHEIO: begin
        if (dado_valido) begin
          ovf_d = 1'b1;
        end
        if (run_s) begin
          state_d = EXECUTA;
        end
      end

      EXECUTA: begin
        if (!run_s) begin
          state_d    = OCIOSO;
          ptr_d      = '0;
          palavras_d = '0;
          ram_end_d  = '0;
          ovf_d      = 1'b0;
`ifdef CARREGADOR_VERIFICA_EN
          ver_d      = 1'b0;
`endif
        end
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase

    // Outputs registered from the next state so they line up with state_q.
    ram_we_d = (state_d == ESCREVE);
    pronto_d = (state_d == OCIOSO);
    exec_d   = (state_d == EXECUTA);
  end

  always_ff @(posedge clk_in or negedge limpar_iniciar_n) begin
    if (!limpar_iniciar_n) begin
      state_q    <= OCIOSO;
      ptr_q      <= '0;
      palavras_q <= '0;
      ram_end_q  <= '0;
      ram_dado_q <= '0;
      ram_we_q   <= 1'b0;
      pronto_q   <= 1'b0;
      exec_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef CARREGADOR_VERIFICA_EN
      ver_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      palavras_q <= palavras_d;
      ram_end_q  <= ram_end_d;
      ram_dado_q <= ram_dado_d;
      ram_we_q   <= ram_we_d;
      pronto_q   <= pronto_d;
      exec_q     <= exec_d;
      ovf_q      <= ovf_d;
`ifdef CARREGADOR_VERIFICA_EN
      ver_q      <= ver_d;
`endif
    end
  end

  // The CPU address bypasses the register so MAR changes reach the RAM
  // in the same cycle.
  assign ram_end       = exec_q ? cpu_end : ram_end_q;
  assign ram_dado      = ram_dado_q;
  assign ram_we        = ram_we_q;
  assign cpu_executar  = exec_q;
  assign palavras      = palavras_q;
  assign erro_overflow = ovf_q;
  assign estado        = state_q;
`ifdef CARREGADOR_VERIFICA_EN
  assign erro_verificacao = ver_q;
`else
  assign erro_verificacao = 1'b0;
`endif

endmodule

// File: tb/tb_sap1_carregador_ram.sv
// Testbench for sap1_carregador_ram (ADDR_W=4, DATA_W=8).
// The reference model is a word counter plus an expected-write queue; a RAM
// model (synchronous read, write-first) corrupts address 2 so the verify
// build has something to catch.
module tb_sap1_carregador_ram;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef CARREGADOR_VERIFICA_EN
  localparam int VERIF  = 1;
  localparam int PERIOD = 3;
`else
  localparam int VERIF  = 0;
  localparam int PERIOD = 2;
`endif

  logic          clk;
  logic          rst_n;
  logic          run_prog;
  logic          dado_valido;
  logic [DW-1:0] dado_in;
  logic          dado_pronto;
  logic [AW-1:0] cpu_end;
  logic [AW-1:0] ram_end;
  logic [DW-1:0] ram_dado;
  logic          ram_we;
  logic [DW-1:0] ram_dado_lido;
  logic          cpu_executar;
  logic [AW:0]   palavras;
  logic          erro_overflow;
  logic          erro_verificacao;
  logic [2:0]    estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    tx_q[$];
  logic [AW+DW-1:0] mon_e;
  logic             we_prev;
  logic [DW-1:0]    mem[16];
  logic [DW-1:0]    rd_q;

  sap1_carregador_ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in           (clk),
    .limpar_iniciar_n (rst_n),
    .run_prog         (run_prog),
    .dado_valido      (dado_valido),
    .dado_in          (dado_in),
    .dado_pronto      (dado_pronto),
    .cpu_end          (cpu_end),
    .ram_end          (ram_end),
    .ram_dado         (ram_dado),
    .ram_we           (ram_we),
    .ram_dado_lido    (ram_dado_lido),
    .cpu_executar     (cpu_executar),
    .palavras         (palavras),
    .erro_overflow    (erro_overflow),
    .erro_verificacao (erro_verificacao),
    .estado           (estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_end] <= (ram_end == 4'd2) ? ~ram_dado : ram_dado;
      rd_q         <= (ram_end == 4'd2) ? ~ram_dado : ram_dado;
    end else begin
      rd_q <= mem[ram_end];
    end
  end
  assign ram_dado_lido = rd_q;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        check("we_single_cycle", 32'(we_prev), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=addr %0h data %0h want=no write", ram_end, ram_dado);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 32'(ram_end), 32'(mon_e[AW+DW-1:DW]));
          check("write_data", 32'(ram_dado), 32'(mon_e[DW-1:0]));
        end
      end
      we_prev = ram_we;
    end else begin
      we_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_prog = 1'b0;
    dado_valido = 1'b0;
    cpu_end = '0;
    exp_q.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_end", 32'(ram_end), 32'd0);
    check("rst_ram_dado", 32'(ram_dado), 32'd0);
    check("rst_palavras", 32'(palavras), 32'd0);
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_pronto", 32'(dado_pronto), 32'd0);
    check("rst_exec", 32'(cpu_executar), 32'd0);
    check("rst_ovf", 32'(erro_overflow), 32'd0);
    check("rst_ver", 32'(erro_verificacao), 32'd0);
    rst_n = 1'b1;
    settle(1);
  endtask

  // Offers every word in tx_q back to back, holding dado_valido high.
  task automatic stream_words();
    int first_c, last_c, n_ok, waited;
    bit ok;
    n_ok = 0; first_c = 0; last_c = 0;
    foreach (tx_q[i]) begin
      dado_valido = 1'b1;
      dado_in = tx_q[i];
      ok = 0;
      waited = 0;
      while (!ok && waited < 8) begin
        @(negedge clk);
        if (dado_pronto) ok = 1;
        else waited++;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got=no ready want=ready word=%0h", tx_q[i]);
      end else begin
        exp_q.push_back({4'(model_cnt), tx_q[i]});
        model_cnt++;
        if (n_ok == 0) first_c = cyc;
        last_c = cyc;
        n_ok++;
      end
      @(posedge clk);
      #1;
    end
    dado_valido = 1'b0;
    dado_in = 8'($urandom);
    if (n_ok == tx_q.size() && n_ok > 1)
      check("throughput", 32'(last_c - first_c), 32'(PERIOD * (n_ok - 1)));
  endtask

  task automatic go_exec();
    run_prog = 1'b1;
    settle(3);
    check("exec_estado", 32'(estado), 32'd4);
    check("exec_flag", 32'(cpu_executar), 32'd1);
  endtask

  task automatic go_prog();
    dado_valido = 1'b0;
    run_prog = 1'b0;
    settle(3);
    model_cnt = 0;
    check("prog_estado", 32'(estado), 32'd0);
    check("prog_palavras", 32'(palavras), 32'd0);
    check("prog_ovf", 32'(erro_overflow), 32'd0);
    check("prog_ver", 32'(erro_verificacao), 32'd0);
    check("prog_exec", 32'(cpu_executar), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [DW-1:0] w;
    rst_n = 1'b0; run_prog = 1'b0; dado_valido = 1'b0; dado_in = '0; cpu_end = '0;
    we_prev = 1'b0;
    foreach (mem[i]) mem[i] = '0;

    // 1: single word after reset
    do_reset();
    @(negedge clk);
    check("ready_after_reset", 32'(dado_pronto), 32'd1);
    @(posedge clk); #1;
    tx_q = '{8'h1D};
    stream_words();
    settle(3);
    check("one_palavras", 32'(palavras), 32'd1);

    // 2: fill all 16 addresses, then overflow
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    stream_words();
    settle(3);
    check("full_palavras", 32'(palavras), 32'd16);
    check("full_estado", 32'(estado), 32'd3);
    check("full_pronto", 32'(dado_pronto), 32'd0);
    check("full_ovf_before", 32'(erro_overflow), 32'd0);
    dado_valido = 1'b1; dado_in = 8'hEE;
    settle(3);
    dado_valido = 1'b0;
    settle(1);
    check("ovf_set", 32'(erro_overflow), 32'd1);
    check("ovf_palavras", 32'(palavras), 32'd16);
    check("ovf_estado", 32'(estado), 32'd3);
    go_exec();
    check("ovf_sticky_exec", 32'(erro_overflow), 32'd1);
    go_prog();

    // 3: random-length random program
    for (int r = 0; r < 3; r++) begin
      do_reset();
      n = $urandom_range(1, 16);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      stream_words();
      settle(3);
      check("rand_palavras", 32'(palavras), 32'(n));
      check("rand_estado", 32'(estado), (n == 16) ? 32'd3 : 32'd0);
      check("rand_pronto", 32'(dado_pronto), (n == 16) ? 32'd0 : 32'd1);
    end

    // 4: execution mode after 3 words
    do_reset();
    tx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    stream_words();
    settle(3);
    run_prog = 1'b1;
    @(posedge clk); @(negedge clk);
    check("exec_edge1", 32'(cpu_executar), 32'd0);
    @(posedge clk); @(negedge clk);
    check("exec_edge2", 32'(cpu_executar), 32'd0);
    @(posedge clk); @(negedge clk);
    check("exec_edge3", 32'(cpu_executar), 32'd1);
    cpu_end = 4'h7;
    #1;
    check("cpu_end_7", 32'(ram_end), 32'h7);
    dado_valido = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cpu_end = 4'($urandom);
      dado_in = 8'($urandom);
      @(negedge clk);
      check("cpu_end_follow", 32'(ram_end), 32'(cpu_end));
      check("exec_pronto", 32'(dado_pronto), 32'd0);
    end
    check("exec_palavras", 32'(palavras), 32'd3);
    @(posedge clk); #1;
    go_prog();
    tx_q = '{8'h5A};
    stream_words();
    settle(3);
    check("reload_palavras", 32'(palavras), 32'd1);

    // 5: reset during the write cycle
    do_reset();
    dado_valido = 1'b1; dado_in = 8'hA5;
    @(negedge clk);
    check("escreve_pronto", 32'(dado_pronto), 32'd1);
    @(posedge clk); #1;
    dado_valido = 1'b0;
    check("escreve_we", 32'(ram_we), 32'd1);
    check("escreve_dado", 32'(ram_dado), 32'hA5);
    check("escreve_end", 32'(ram_end), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_we", 32'(ram_we), 32'd0);
    check("async_dado", 32'(ram_dado), 32'd0);
    check("async_estado", 32'(estado), 32'd0);
    check("async_palavras", 32'(palavras), 32'd0);

    // 6: run request arriving on the handshake edge
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom));
    stream_words();
    settle(3);
    run_prog = 1'b1;
    @(posedge clk); #1;
    w = 8'($urandom);
    dado_valido = 1'b1; dado_in = w;
    @(negedge clk);
    check("simul_pronto", 32'(dado_pronto), 32'd1);
    exp_q.push_back({4'(model_cnt), w});
    model_cnt++;
    @(posedge clk); #1;
    dado_valido = 1'b0;
    check("simul_we", 32'(ram_we), 32'd1);
    settle(1);
    check("simul_estado1", 32'(estado), VERIF ? 32'd2 : 32'd4);
    if (VERIF == 1) settle(1);
    check("simul_estado2", 32'(estado), 32'd4);
    check("simul_palavras", 32'(palavras), 32'd6);
    go_prog();

    // 7: read-back check; RAM model corrupts address 2
    do_reset();
    tx_q = '{8'($urandom), 8'($urandom)};
    stream_words();
    settle(4);
    check("ver_clean", 32'(erro_verificacao), 32'd0);
    tx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    stream_words();
    settle(4);
    check("ver_flag", 32'(erro_verificacao), 32'(VERIF));
    check("ver_palavras", 32'(palavras), 32'd5);

    settle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap1_carregador_ram.md
Name: sap1_carregador_ram

Overview:
- Parametrised program loader for the SAP-1 program RAM; sits between an external word source (switch bank, UART, or bench) and the RAM port.
- In programming mode it accepts words over a valid/ready handshake and writes them to consecutive addresses.
- In execution mode it hands the RAM address port to the CPU and blocks all writes.
- Replaces manual RAM programming with width/depth-generic, handshake-driven loading.

Parameters:
ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
DATA_W, 8, RAM word width.

Ports:
clk_in  in  1  system clock, rising edge
limpar_iniciar_n  in  1  asynchronous active-low reset
run_prog  in  1  0 = programming mode, 1 = execution mode; asynchronous to the loader, synchronised internally
dado_valido  in  1  source word valid
dado_in  in  DATA_W  source word
dado_pronto  out  1  loader ready to accept a word
cpu_end  in  ADDR_W  CPU address (MAR) used in execution mode
ram_end  out  ADDR_W  address to RAM
ram_dado  out  DATA_W  write data to RAM
ram_we  out  1  RAM write strobe, one cycle per word
ram_dado_lido  in  DATA_W  RAM read data; used only by the verify feature
cpu_executar  out  1  high while the CPU owns the RAM
palavras  out  ADDR_W+1  count of words loaded, 0..2**ADDR_W
erro_overflow  out  1  sticky: word offered while full
erro_verificacao  out  1  sticky: read-back mismatch; tied 0 without the macro
estado  out  3  state code, for debug

Behaviour:
- Reset (async, limpar_iniciar_n=0): state = OCIOSO.
  - All of the following are 0: pointer, palavras, ram_we, dado_pronto, cpu_executar, both error flags, ram_end, ram_dado.
  - ram_we drops immediately, so no partial write survives reset.
- run_prog passes through a 2-flop synchroniser; the state machine sees it 2 cycles later as run_s.
- States (codes): OCIOSO=0, ESCREVE=1, VERIFICA=2 (macro only), CHEIO=3, EXECUTA=4.
- OCIOSO:
  - dado_pronto = !run_s.
  - On dado_valido & dado_pronto: latch dado_in to ram_dado and the pointer to ram_end, then go to ESCREVE.
  - run_s=1 -> EXECUTA.
- ESCREVE:
  - ram_we=1 for exactly this cycle; dado_pronto=0.
  - Pointer and palavras increment.
  - Next state: VERIFICA if the macro is defined; otherwise CHEIO if palavras reaches 2**ADDR_W; otherwise OCIOSO.
- Throughput: at most one word every 2 cycles without the macro, every 3 cycles with it.
- CHEIO: dado_pronto=0. dado_valido=1 sets erro_overflow; the word is dropped. run_s=1 -> EXECUTA.
- Pointer wrap: the pointer is ADDR_W bits and would wrap to 0 after the last address. It is never used after wrap because CHEIO blocks further writes.
- EXECUTA:
  - cpu_executar=1; ram_end = cpu_end combinationally.
  - ram_we=0 and dado_pronto=0.
  - run_s=0 -> OCIOSO, clearing pointer, palavras and both error flags so a new program can be loaded.
- Simultaneous events:
  - run_s rising while in ESCREVE/VERIFICA: the write (and verify) completes, then go to EXECUTA, never OCIOSO.
  - dado_valido and run_s both high in OCIOSO: run_s wins, and no handshake occurs because dado_pronto is already 0.
- dado_in is sampled only on the handshake cycle; the source may change it at any other time.

Optional Feature:
- Macro: CARREGADOR_VERIFICA_EN.
- Defined:
  - After ESCREVE, the VERIFICA state drives the same ram_end with ram_we=0.
  - Compares ram_dado_lido with ram_dado (synchronous-read RAM, data valid in VERIFICA).
  - A mismatch sets erro_verificacao (sticky until reset or return from EXECUTA).
  - Then CHEIO/OCIOSO per the normal rule.
- Undefined: no VERIFICA state; ram_dado_lido is ignored; erro_verificacao is constant 0.

Decomposition:
- Shared package sap1_pkg: state enum and codes, default ADDR_W=4 and DATA_W=8 constants.
- Sub-module sap1_sincronizador: parametrised-width 2-flop synchroniser with async active-low reset. Used for run_prog and reusable elsewhere in SAP-1.

Test Plan:
- Reset release, offer 0x1D with valid: dado_pronto=1; ram_we pulses once at ram_end=0 with ram_dado=0x1D; palavras=1.
- Stream 16 words 0x00..0x0F: writes to addresses 0..15 in order; palavras=16; state CHEIO; dado_pronto=0. A 17th valid sets erro_overflow=1 with no ram_we.
- Raise run_prog after 3 words: cpu_executar=1 on the 3rd edge; ram_end follows cpu_end=0x7; dado_valido ignored. Drop run_prog: palavras=0, pointer=0, errors cleared.
- Assert limpar_iniciar_n=0 during the ESCREVE cycle: ram_we falls without waiting for a clock; all outputs 0.
- run_prog rising on the same edge as a handshake: write of the word completes at its address, then EXECUTA.
- With CARREGADOR_VERIFICA_EN, the RAM model corrupts address 2: erro_verificacao=1 after the 3rd word, stays set; words 4+ still load.
